// File: rtl/board_scan_pkg.sv
// Shared constants and queen-field helpers for the board scanner.
// A board is 8 queens packed as 16 three-bit fields: row, column, row, column, ... from the MSB down.
package board_scan_pkg;

  localparam int QUEENS    = 8;
  localparam int FIELD_W   = 3;
  localparam int BOARD_DIM = 8;
  localparam int POS_W     = QUEENS * 2 * FIELD_W;

  typedef struct packed {
    logic [FIELD_W-1:0] row;
    logic [FIELD_W-1:0] col;
  } queen_t;

  function automatic queen_t queen_at(input logic [POS_W-1:0] p, input int i);
    queen_t q;
    q.row = p[POS_W-1-FIELD_W*(2*i)   -: FIELD_W];
    q.col = p[POS_W-1-FIELD_W*(2*i+1) -: FIELD_W];
    return q;
  endfunction

  // Two queens attack each other if they share a row, a column or a diagonal.
  function automatic logic queens_clash(input queen_t a, input queen_t b);
    logic [FIELD_W-1:0] dr;
    logic [FIELD_W-1:0] dc;
    dr = (a.row > b.row) ? a.row - b.row : b.row - a.row;
    dc = (a.col > b.col) ? a.col - b.col : b.col - a.col;
    return (a.row == b.row) || (a.col == b.col) || (dr == dc);
  endfunction

endpackage

// File: rtl/board_row_decode.sv
// Turns a board snapshot and a row index into the lit-column pattern for that row.
module board_row_decode
  import board_scan_pkg::*;
(
  input  logic [POS_W-1:0]     snap,
  input  logic [FIELD_W-1:0]   row,
  output logic [BOARD_DIM-1:0] cols
);

  queen_t q;

  // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cols = '0;
    q    = '0;
    for (int i = 0; i < QUEENS; i++) begin
      q = queen_at(snap, i);
      if (q.row == row) cols[q.col] = 1'b1;
    end
  end

endmodule

// File: rtl/board_scan.sv
// Multiplexed 8x8 LED scanner for an 8-queens board; one row is shown for DIV cycles.
// Define BOARD_SCAN_CONFLICT_EN to build the per-frame attack detector; otherwise conflict is tied low.
module board_scan
  import board_scan_pkg::*;
#(
  parameter int DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] pos,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_tick,
  output logic        conflict
);

  localparam int              CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0]     presc;
  logic [FIELD_W-1:0]   row_idx;
  logic [FIELD_W-1:0]   row_next;
  logic [POS_W-1:0]     snap;
  logic [POS_W-1:0]     frame_src;
  logic [BOARD_DIM-1:0] dec_cols;
  logic                 advance;
  logic                 wrap;

  assign advance  = (presc == CNT_LAST);
  assign wrap     = advance && (row_idx == 3'd7);
  assign row_next = row_idx + 3'd1;
  // On the frame-start cycle row 0 must already come from the board being captured.
  assign frame_src = wrap ? pos : snap;

  board_row_decode u_decode (
    .snap (frame_src),
    .row  (row_next),
    .cols (dec_cols)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= CNT_LAST;
      row_idx    <= 3'd7;
      // NOTE: the snapshot is a plain register, not a RAM, so clearing it in reset is cheap and keeps frame contents defined.
      snap       <= '0;
      row_sel    <= '0;
      col_data   <= '0;
      frame_tick <= 1'b0;
    end else begin
      presc      <= advance ? '0 : presc + 1'b1;
      frame_tick <= wrap;
      if (advance) begin
        row_idx  <= row_next;
        row_sel  <= 8'h01 << row_next;
        col_data <= dec_cols;
      end
      if (wrap) snap <= pos;
    end
  end

`ifdef BOARD_SCAN_CONFLICT_EN
  logic conflict_next;

  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < QUEENS; i++)
      for (int j = i + 1; j < QUEENS; j++)
        if (queens_clash(queen_at(pos, i), queen_at(pos, j))) conflict_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       conflict <= 1'b0;
    else if (wrap) conflict <= conflict_next;
  end
`else
  assign conflict = 1'b0;
`endif

endmodule
